// File: rtl/fifo_wr_ctrl.sv
// Write-domain pointer/flag controller for the asynchronous FIFO.
// Optional almost-full output is enabled by defining FIFO_ALMOST_FULL_EN.
module fifo_wr_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int AF_MARGIN  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH:0]   rptr_gray_sync,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  mem_we,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  full,
    output logic                  overflow
`ifdef FIFO_ALMOST_FULL_EN
    ,
    output logic                  almost_full
`endif
);

    localparam int AW = ADDR_WIDTH;

    // Handshake: wr_en is the producer's valid, ~full is ready; a write
    // transfers on a posedge where both are high (and rst is low). A request
    // while full is dropped and latches overflow.
    logic            accept;
    logic [AW:0]     wbin;
    logic [AW:0]     wbin_next;
    logic [AW:0]     gray_next;
    logic [AW:0]     rptr_full_match;

    // rst gates the write so the RAM is never written on a reset edge.
    assign accept    = wr_en & ~full & ~rst;
    assign mem_we    = accept;
    assign wbin_next = wbin + {{AW{1'b0}}, accept};
    assign gray_next = wbin_next ^ (wbin_next >> 1);
    assign wr_addr   = wbin[AW-1:0];

    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    assign rptr_full_match = {~rptr_gray_sync[AW:AW-1], rptr_gray_sync[AW-2:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            wbin      <= '0;
            wptr_gray <= '0;
            full      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            wbin      <= wbin_next;
            wptr_gray <= gray_next;
            full      <= (gray_next == rptr_full_match);
            if (wr_en && full)
                overflow <= 1'b1;
        end
    end

`ifdef FIFO_ALMOST_FULL_EN
    logic [AW:0] rbin;
    logic [AW:0] level_next;

    always_comb begin
        rbin[AW] = rptr_gray_sync[AW];
        for (int i = AW - 1; i >= 0; i--)
            rbin[i] = rbin[i+1] ^ rptr_gray_sync[i];
    end

    assign level_next = wbin_next - rbin;

    // Full implies level_next == depth, so almost_full covers full by construction.
    always_ff @(posedge clk) begin
        if (rst)
            almost_full <= 1'b0;
        else
            almost_full <= (level_next >= (AW+1)'((1 << AW) - AF_MARGIN));
    end
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl: directed scenarios plus random
// traffic checked against a count-based model of FIFO occupancy.
module tb_fifo_wr_ctrl;

    localparam int AW    = 4;
    localparam int AFM   = 2;
    localparam int DEPTH = 1 << AW;
    localparam int PMOD  = 2 * DEPTH;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [AW:0]   rptr_gray_sync;
    logic [AW-1:0] wr_addr;
    logic          mem_we;
    logic [AW:0]   wptr_gray;
    logic          full;
    logic          overflow;
`ifdef FIFO_ALMOST_FULL_EN
    logic          almost_full;
`endif

    fifo_wr_ctrl #(.ADDR_WIDTH(AW), .AF_MARGIN(AFM)) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en),
        .rptr_gray_sync (rptr_gray_sync),
        .wr_addr        (wr_addr),
        .mem_we         (mem_we),
        .wptr_gray      (wptr_gray),
        .full           (full),
        .overflow       (overflow)
`ifdef FIFO_ALMOST_FULL_EN
        ,
        .almost_full    (almost_full)
`endif
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // model: counts of accepted writes and completed reads, modulo 2*depth
    int   m_w   = 0;
    int   rcnt  = 0;
    logic m_full = 1'b0;
    logic m_ovf  = 1'b0;
    logic m_af   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [AW:0] to_gray(input int n);
        logic [AW:0] b;
        b = (AW+1)'(n % PMOD);
        return b ^ (b >> 1);
    endfunction

    // One clock of stimulus: drive at negedge, check the combinational
    // outputs, advance the model, check registered outputs after posedge.
    task automatic step(input logic r, input logic w);
        logic exp_acc;
        int   lvl;
        @(negedge clk);
        rst            = r;
        wr_en          = w;
        rptr_gray_sync = to_gray(rcnt);
        #1;
        exp_acc = w & ~m_full & ~r;
        check("mem_we", 32'(mem_we), 32'(exp_acc));
        if (exp_acc)
            check("wr_addr_at_write", 32'(wr_addr), 32'(m_w % DEPTH));
        if (r) begin
            m_w = 0; m_full = 0; m_ovf = 0; m_af = 0;
        end else begin
            if (w && m_full) m_ovf = 1'b1;
            m_w    = (m_w + int'(exp_acc)) % PMOD;
            lvl    = (m_w - rcnt + PMOD) % PMOD;
            m_full = (lvl == DEPTH);
            m_af   = (lvl >= DEPTH - AFM);
        end
        @(posedge clk);
        #1;
        check("wptr_gray", 32'(wptr_gray), 32'(to_gray(m_w)));
        check("wr_addr", 32'(wr_addr), 32'(m_w % DEPTH));
        check("full", 32'(full), 32'(m_full));
        check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef FIFO_ALMOST_FULL_EN
        check("almost_full", 32'(almost_full), 32'(m_af));
`endif
    endtask

    initial begin
        logic [AW:0] prev_g;
        int          lvl;
        rst = 1'b0; wr_en = 1'b0; rptr_gray_sync = '0;

        // reset with a write request pending
        rcnt = 0;
        step(1'b1, 1'b1);
        check("reset_full_const", 32'(full), 32'd0);

        // fill 16 entries
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1);
`ifdef FIFO_ALMOST_FULL_EN
            if (i == DEPTH - AFM - 1)
                check("af_after_14", 32'(almost_full), 32'd1);
`endif
        end
        check("fill_gray_11000", 32'(wptr_gray), 32'b11000);
        check("fill_full", 32'(full), 32'd1);

        // overflow: 3 writes while full, then idle
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        check("ovf_gray_hold", 32'(wptr_gray), 32'b11000);
        step(1'b0, 1'b0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // drain release: one entry read
        rcnt = 1;
        step(1'b0, 1'b0);
        check("drain_full_clear", 32'(full), 32'd0);
        step(1'b0, 1'b1);
        check("drain_refull", 32'(full), 32'd1);

        // reset clears overflow
        step(1'b1, 1'b0);
        check("rst_ovf_clear", 32'(overflow), 32'd0);

        // wrap: read pointer one behind the write pointer
        prev_g = wptr_gray;
        for (int i = 0; i < 40; i++) begin
            rcnt = (m_w + PMOD - 1) % PMOD;
            step(1'b0, 1'b1);
            check("wrap_gray_1bit", 32'($countones(wptr_gray ^ prev_g)), 32'd1);
            check("wrap_no_full", 32'(full), 32'd0);
            prev_g = wptr_gray;
        end

        // reset mid-fill
        rcnt = 0;
        step(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        check("midrst_addr", 32'(wr_addr), 32'd0);
        step(1'b0, 1'b1);
        check("resume_addr", 32'(wr_addr), 32'd1);

        // random traffic with a monotonic read pointer
        for (int i = 0; i < 400; i++) begin
            lvl = (m_w - rcnt + PMOD) % PMOD;
            if (lvl > 0 && $urandom_range(0, 2) == 0)
                rcnt = (rcnt + $urandom_range(1, lvl)) % PMOD;
            if ($urandom_range(0, 99) == 0) begin
                rcnt = 0;
                step(1'b1, 1'($urandom_range(0, 1)));
            end else begin
                step(1'b0, 1'($urandom_range(0, 3) != 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
